// File: rtl/sprite_row_fetcher.sv
// Sprite row fetcher: walks one sprite row out of a bit-serial sprite ROM
// (one pixel per cycle, one-cycle ROM latency) and presents it as a parallel line.
module sprite_row_fetcher #(
    parameter int SPR_W  = 16,
    parameter int SPR_H  = 8,
    parameter int ADDR_W = 19
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_row,
    input  logic [3:0]        req_sel,
    input  logic              flush,
    output logic [ADDR_W-1:0] read_address,
    output logic [3:0]        rom_sel,
    input  logic              data_Out,
    output logic              line_valid,
    output logic [SPR_W-1:0]  line_data,
    input  logic              line_ack
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [7:0]        row_q, row_d;
    logic [3:0]        sel_q, sel_d;
    logic              oor_q, oor_d;
    logic [SPR_W-1:0]  line_data_q, line_data_d;
    logic              line_valid_q, line_valid_d;
    logic [CW-1:0]     cap_idx;
    logic              cap_en;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        sel_d        = sel_q;
        oor_d        = oor_q;
        line_data_d  = line_data_q;
        line_valid_d = line_valid_q;
        cap_en       = 1'b0;
        // ROM data seen now belongs to the column addressed one cycle earlier
        cap_idx      = col_q - CW'(1);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = FETCH;
                    col_d   = '0;
                    row_d   = req_row;
                    sel_d   = req_sel;
                    oor_d   = ({24'd0, req_row} >= 32'(SPR_H));
                end
            end
            FETCH: begin
                cap_en = (col_q != '0);
                if (col_q == CW'(SPR_W - 1)) begin
                    state_d = DRAIN;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            DRAIN: begin
                cap_en       = 1'b1;
                cap_idx      = CW'(SPR_W - 1);
                col_d        = '0;
                line_valid_d = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (line_ack) begin
                    line_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cap_en) begin
            line_data_d[cap_idx] = data_Out & ~oor_q;
        end

        // flush wins over accept and ack alike
        if (flush) begin
            state_d      = IDLE;
            col_d        = '0;
            line_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            sel_q        <= '0;
            oor_q        <= 1'b0;
            line_data_q  <= '0;
            line_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            sel_q        <= sel_d;
            oor_q        <= oor_d;
            line_data_q  <= line_data_d;
            line_valid_q <= line_valid_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign rom_sel      = sel_q;
    assign line_valid   = line_valid_q;
    assign line_data    = line_data_q;
    assign read_address = (state_q == FETCH && !oor_q)
                        ? ADDR_W'(row_q) * ADDR_W'(SPR_W) + ADDR_W'(col_q)
                        : '0;

endmodule
